// File: rtl/fetch_if.sv
// Fetch-to-memory/decode bundle for the instruction-fetch sequencer.
//
// Signals:
//   pc        sequencer -> memory  16-bit fetch address (registered)
//   instr     memory -> sequencer  mem[pc] one cycle after the sampling edge
//   ir        sequencer -> decode  instruction register
//   ir_valid  sequencer -> decode  ir holds an undelivered instruction
//   ir_ready  decode -> sequencer  decode can take ir this cycle
//   br_taken  decode -> sequencer  redirect qualifier
//   br_target decode -> sequencer  redirect address
//   reti      decode -> sequencer  return from interrupt
//   irq       system -> sequencer  level interrupt request
//   irq_ack   sequencer -> system  one-cycle pulse when an interrupt is taken
//   epc       sequencer -> decode  saved return address
//   halted    sequencer -> system  sequencer is halted
//   resume    system -> sequencer  leave the halted state
//
// Handshake: ir is transferred on a rising clk edge where ir_valid and
// ir_ready are both high (the accept edge). Once ir_valid is high, ir, pc and
// ir_valid stay unchanged until that edge; ir_ready may be driven freely and
// does not have to wait for ir_valid. br_taken, br_target and reti only have
// meaning on the accept edge.
interface fetch_if;
  logic [15:0] pc;
  logic [15:0] instr;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        br_taken;
  logic [15:0] br_target;
  logic        reti;
  logic        irq;
  logic        irq_ack;
  logic [15:0] epc;
  logic        halted;
  logic        resume;

  modport master (
    output pc, ir, ir_valid, irq_ack, epc, halted,
    input  instr, ir_ready, br_taken, br_target, reti, irq, resume
  );

  modport slave (
    input  pc, ir, ir_valid, irq_ack, epc, halted,
    output instr, ir_ready, br_taken, br_target, reti, irq, resume
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller. It drives pc into a synchronous instruction
// memory with a one-cycle read latency, captures the returned word into ir, and
// offers ir to decode through the valid/ready handshake on the fetch_if bundle.
// The next pc comes from sequential increment, a branch redirect, an interrupt
// vector with a saved return address, or a return from interrupt. A fetched
// HALT_OPCODE word stops the sequencer and is never delivered to decode.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   bus        fetch_if.master (pc/instr memory side, ir handshake, irq, halt)
//   state_dbg  current FSM state (0 ADDR, 1 LATCH, 2 HOLD, 3 HALT)
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0001,
  parameter logic [15:0] IRQ_VECTOR  = 16'h0000,
  parameter logic [15:0] HALT_OPCODE = 16'hFFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_if.master       bus,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    S_ADDR  = 2'd0,  // pc stable; memory samples it at the end edge
    S_LATCH = 2'd1,  // instr holds mem[pc]
    S_HOLD  = 2'd2,  // ir offered to decode
    S_HALT  = 2'd3
  } state_t;

  state_t      state;
  logic        ie;
  logic [15:0] pc_inc;
  logic [15:0] seq_next;

  assign state_dbg = state;
  assign pc_inc    = bus.pc + 16'd1;
  // Return address for an interrupt taken on the accept edge: a branching
  // instruction returns to its target rather than to the next word.
  assign seq_next  = bus.br_taken ? bus.br_target : pc_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_ADDR;
      ie           <= 1'b1;
      bus.pc       <= RESET_PC;
      bus.ir       <= 16'h0000;
      bus.ir_valid <= 1'b0;
      bus.irq_ack  <= 1'b0;
      bus.epc      <= 16'h0000;
      bus.halted   <= 1'b0;
    end else begin
      bus.irq_ack <= 1'b0;
      case (state)
        S_ADDR: state <= S_LATCH;

        S_LATCH: begin
          if (bus.instr == HALT_OPCODE) begin
            bus.halted <= 1'b1;
            state      <= S_HALT;
          end else begin
            bus.ir       <= bus.instr;
            bus.ir_valid <= 1'b1;
            state        <= S_HOLD;
          end
        end

        S_HOLD: begin
          // ir_valid is always high here, so ir_ready alone marks the accept.
          if (bus.ir_ready) begin
            bus.ir_valid <= 1'b0;
            state        <= S_ADDR;
            if (bus.irq && ie) begin
              bus.epc     <= seq_next;
              bus.pc      <= IRQ_VECTOR;
              ie          <= 1'b0;
              bus.irq_ack <= 1'b1;
            end else if (bus.reti) begin
              bus.pc <= bus.epc;
              ie     <= 1'b1;
            end else if (bus.br_taken) begin
              bus.pc <= bus.br_target;
            end else begin
              bus.pc <= pc_inc;
            end
          end
        end

        S_HALT: begin
          // pc still addresses the halt word, so the return point is pc + 1.
          if (bus.irq && ie) begin
            bus.epc     <= pc_inc;
            bus.pc      <= IRQ_VECTOR;
            ie          <= 1'b0;
            bus.irq_ack <= 1'b1;
            bus.halted  <= 1'b0;
            state       <= S_ADDR;
          end else if (bus.resume) begin
            bus.pc     <= pc_inc;
            bus.halted <= 1'b0;
            state      <= S_ADDR;
          end
        end

        default: state <= S_ADDR;
      endcase
    end
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that drives the program counter into the synchronous instruction memory and hands each fetched word to decode through a valid/ready handshake. It applies sequential increment, branch redirects, interrupt vectoring with saved return address, return-from-interrupt, and halt-on-opcode. It sits between the instruction memory (1-cycle registered read) and the decode stage.

## Interface
- RESET_PC, 16'h0001, PC value loaded on reset (address 0 is reserved for the interrupt vector).
- IRQ_VECTOR, 16'h0000, PC loaded when an interrupt is taken.
- HALT_OPCODE, 16'hFFFF, fetched word that halts the sequencer; it is never delivered to decode.
- clk  in  1  system clock, all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- PC  out  16  address to instruction memory; registered.
- INSTR  in  16  memory data; holds mem[PC] in the cycle after the edge that sampled PC.
- IR  out  16  instruction register to decode.
- ir_valid  out  1  IR holds an undelivered instruction.
- ir_ready  in  1  decode accepts IR on an edge where ir_valid & ir_ready (the "accept edge").
- br_taken  in  1  redirect qualifier; sampled only on the accept edge.
- br_target  in  16  redirect address, sampled with br_taken.
- reti  in  1  return from interrupt; sampled only on the accept edge.
- irq  in  1  level interrupt request.
- irq_ack  out  1  one-cycle pulse when an interrupt is taken.
- EPC  out  16  saved return address.
- halted  out  1  sequencer is in HALT.
- resume  in  1  leave HALT; sampled only in HALT.

## Operation
- States: ADDR (PC stable; memory samples PC at the end edge), LATCH (INSTR valid), HOLD (ir_valid=1, awaiting accept), HALT.
- ADDR -> LATCH unconditionally.
- LATCH: if INSTR == HALT_OPCODE, go to HALT with halted <= 1, IR unchanged, ir_valid stays 0. Otherwise IR <= INSTR, ir_valid <= 1, go to HOLD.
- HOLD: no accept means hold; IR and PC stay stable. On the accept edge, ir_valid <= 0, go to ADDR, and load next PC by priority:
  1. irq & ie: EPC <= seq_next, PC <= IRQ_VECTOR, ie <= 0, irq_ack <= 1.
  2. reti: PC <= EPC, ie <= 1.
  3. br_taken: PC <= br_target.
  4. Otherwise PC <= PC + 1.
- seq_next is br_target if br_taken, else PC + 1. An interrupt taken on a branch instruction returns to the branch target.
- HALT: PC holds. irq & ie takes an interrupt (EPC <= PC + 1, PC <= IRQ_VECTOR, ie <= 0, irq_ack <= 1, halted <= 0, go to ADDR). Otherwise resume gives PC <= PC + 1, halted <= 0, go to ADDR. irq & ie has priority over resume.
- ie is an internal interrupt enable. Reset value 1.
- Arithmetic is 16-bit modulo: PC + 1 from 16'hFFFF wraps to 16'h0000.
- br_taken, reti and resume are ignored outside the sampling points above. irq outside HOLD or HALT is not lost while held high; it is taken at the next eligible edge.

## Timing
- Reset (async, immediate): PC = RESET_PC, IR = 16'h0000, ir_valid = 0, irq_ack = 0, EPC = 16'h0000, halted = 0, ie = 1, state ADDR.
- Reset asserted mid-operation aborts any fetch. No partial IR is delivered.
- Call the first edge after rst_n rises e0. Memory latches mem[RESET_PC] at e0. IR and ir_valid update at e1.
- The fetch loop is 3 cycles per instruction with ir_ready held high (ADDR, LATCH, HOLD). Each decode stall cycle adds one.
- irq_ack is high for exactly the one cycle following the taking edge.
- The new PC is visible the cycle after the accept edge. The first vector word is in IR 2 edges later.

## Test plan
- Memory mem[1]=16'h2456, mem[2]=16'hA061, mem[3]=16'h0000; ir_ready=1 -> IR sequence 2456, A061, 0000, with ir_valid rising at e1, e4, e7.
- ir_ready low for 5 cycles while IR=16'h2456 -> IR, PC=1 and ir_valid=1 stable throughout; next fetch PC=2 after the accept.
- Accept at PC=2 with br_taken=1, br_target=16'h0010 -> PC=16'h0010 next cycle. br_taken pulsed in LATCH has no effect.
- irq=1 at accept of PC=5, no branch -> EPC=6, PC=0, irq_ack one-cycle pulse, ie cleared. A second irq is ignored until an accept with reti=1, which gives PC=6.
- mem[3]=16'hFFFF -> halted=1, ir_valid never rises for that word, PC=3. resume pulse gives PC=4 and fetch restarts. irq during HALT vectors with EPC=4.
- PC=16'hFFFF sequential accept -> PC=16'h0000. rst_n dropped in LATCH -> all outputs at reset values immediately, fetch restarts at 16'h0001.
